pckt_rcv: RTL and testbench

PCKT_RCV -- requirements
Module: pckt_rcv

---
 rtl/pckt_rcv_if.sv | 21 ++
 rtl/pckt_rcv.sv | 200 ++++++++++++++++++++
 tb/tb_pckt_rcv.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pckt_rcv_if.sv
// Differential line inputs and packet status outputs of the packet receiver.
// The master modport is the line/host side; the slave modport is the receiver.
interface pckt_rcv_if;
  logic        Bp;
  logic        Am;
  logic        clr_pckt_rdy;
  logic [15:0] rxdata;
  logic        pckt_rdy;
  logic        crc_err;
  logic        frm_err;

  modport master (
    output Bp, Am, clr_pckt_rdy,
    input  rxdata, pckt_rdy, crc_err, frm_err
  );

  modport slave (
    input  Bp, Am, clr_pckt_rdy,
    output rxdata, pckt_rdy, crc_err, frm_err
  );
endinterface

// File: rtl/pckt_rcv.sv
// Differential-line packet receiver: 3-byte packets (data hi, data lo, CRC-8/0x07),
// reporting good packets through pckt_rdy/rxdata and bad ones as error pulses.
module pckt_rcv #(
  parameter int BAUD_DIV = 32,
  parameter int GAP_TO   = 12
) (
  input  logic        clk,
  input  logic        rst,
  pckt_rcv_if.slave   bus
);

  localparam int HALF     = BAUD_DIV / 2;
  localparam int GAP_CLKS = GAP_TO * BAUD_DIV;
  localparam int CW       = $clog2(BAUD_DIV);
  localparam int GW       = $clog2(GAP_CLKS + 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [GW-1:0]   gap_q, gap_d;
  logic [2:0]      bit_q, bit_d;
  logic [1:0]      idx_q, idx_d;
  logic [7:0]      shft_q, shft_d;
  logic [7:0]      byte0_q, byte0_d;
  logic [7:0]      crc_q, crc_d;
  logic [15:0]     rx_q, rx_d;
  logic            rdy_q, rdy_d;
  logic            crce_q, crce_d;
  logic            frme_q, frme_d;
  logic            chk_q, chk_d;
  logic            bp_m_q, bp_s_q, bp_l_q;
  logic            am_m_q, am_s_q;

  logic            line_ok, line_bit, fall, half_hit, baud_hit;
  logic [7:0]      crc_next;

  function automatic logic [7:0] crc8(input logic [7:0] c, input logic [7:0] d);
    logic [7:0] r;
    r = c;
    for (int i = 7; i >= 0; i--) begin
      if (r[7] ^ d[i]) r = {r[6:0], 1'b0} ^ 8'h07;
      else             r = {r[6:0], 1'b0};
    end
    return r;
  endfunction

  // bp_l_q is the previous synchronized Bp, used only for start-edge detection
  always_ff @(posedge clk) begin
    if (rst) begin
      bp_m_q <= 1'b1;
      bp_s_q <= 1'b1;
      bp_l_q <= 1'b1;
      am_m_q <= 1'b0;
      am_s_q <= 1'b0;
    end else begin
      bp_m_q <= bus.Bp;
      bp_s_q <= bp_m_q;
      bp_l_q <= bp_s_q;
      am_m_q <= bus.Am;
      am_s_q <= am_m_q;
    end
  end

  assign line_ok  = bp_s_q ^ am_s_q;
  assign line_bit = bp_s_q;
  assign fall     = bp_l_q & ~bp_s_q;
  assign half_hit = (cnt_q == CW'(HALF - 1));
  assign baud_hit = (cnt_q == CW'(BAUD_DIV - 1));
  assign crc_next = crc8(crc_q, shft_q);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    gap_d   = '0;
    bit_d   = bit_q;
    idx_d   = idx_q;
    shft_d  = shft_q;
    byte0_d = byte0_q;
    crc_d   = crc_q;
    rx_d    = rx_q;
    rdy_d   = rdy_q;
    crce_d  = 1'b0;
    frme_d  = 1'b0;
    chk_d   = 1'b0;

    if (bus.clr_pckt_rdy) rdy_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (fall) begin
          state_d = START;
        end else if (idx_q != 2'd0) begin
          if (gap_q == GW'(GAP_CLKS - 1)) begin
            frme_d = 1'b1;
            idx_d  = 2'd0;
          end else begin
            gap_d = gap_q + 1'b1;
          end
        end
      end
      START: begin
        if (half_hit) begin
          cnt_d = '0;
          if (!line_ok) begin
            frme_d  = 1'b1;
            idx_d   = 2'd0;
            state_d = IDLE;
          end else if (line_bit) begin
            state_d = IDLE;
          end else begin
            state_d = DATA;
            bit_d   = 3'd0;
            if (idx_q == 2'd0) begin
              rdy_d = 1'b0;
              crc_d = 8'h00;
            end
          end
        end
      end
      DATA: begin
        if (baud_hit) begin
          cnt_d = '0;
          if (!line_ok) begin
            frme_d  = 1'b1;
            idx_d   = 2'd0;
            state_d = IDLE;
          end else begin
            shft_d = {line_bit, shft_q[7:1]};
            bit_d  = bit_q + 3'd1;
            if (bit_q == 3'd7) state_d = STOP;
          end
        end
      end
      STOP: begin
        if (baud_hit) begin
          cnt_d   = '0;
          state_d = IDLE;
          if (!line_ok || !line_bit) begin
            frme_d = 1'b1;
            idx_d  = 2'd0;
          end else begin
            crc_d = crc_next;
            unique case (idx_q)
              2'd0:    begin byte0_d = shft_q;            idx_d = 2'd1; end
              2'd1:    begin rx_d = {byte0_q, shft_q};    idx_d = 2'd2; end
              default: begin chk_d = 1'b1;                idx_d = 2'd0; end
            endcase
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Verdict on the CRC lands one clock after the last stop bit; a set beats a clear
    if (chk_q) begin
      if (crc_q == 8'h00) rdy_d  = 1'b1;
      else                crce_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      gap_q   <= '0;
      bit_q   <= 3'd0;
      idx_q   <= 2'd0;
      shft_q  <= 8'h00;
      byte0_q <= 8'h00;
      crc_q   <= 8'h00;
      rx_q    <= 16'h0000;
      rdy_q   <= 1'b0;
      crce_q  <= 1'b0;
      frme_q  <= 1'b0;
      chk_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gap_q   <= gap_d;
      bit_q   <= bit_d;
      idx_q   <= idx_d;
      shft_q  <= shft_d;
      byte0_q <= byte0_d;
      crc_q   <= crc_d;
      rx_q    <= rx_d;
      rdy_q   <= rdy_d;
      crce_q  <= crce_d;
      frme_q  <= frme_d;
      chk_q   <= chk_d;
    end
  end

  assign bus.rxdata   = rx_q;
  assign bus.pckt_rdy = rdy_q;
  assign bus.crc_err  = crce_q;
  assign bus.frm_err  = frme_q;

endmodule

// File: tb/tb_pckt_rcv.sv
// Bench for pckt_rcv: bit-level line driver, packet-level expectation model and a
// per-cycle compare process, with directed cases followed by random packets.
module tb_pckt_rcv;
  localparam int BD = 16;
  localparam int GT = 12;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pckt_rcv_if bus();

  pckt_rcv #(.BAUD_DIV(BD), .GAP_TO(GT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int tests = 0;
  int fails = 0;

  logic [15:0] exp_rx;
  logic        exp_rdy;
  int          exp_frm, exp_crc, obs_frm, obs_crc, rdy_rise;
  logic        rx_dc, rdy_dc, hold_mode, run_cmp;
  logic        prev_rdy, prev_frm, prev_crc;
  logic [7:0]  m_b0, m_b1;

  // CRC as the remainder of data*x^8 divided by x^8+x^2+x+1
  function automatic logic [7:0] crc_ref(input logic [15:0] d);
    logic [23:0] r;
    r = {d, 8'h00};
    for (int b = 23; b >= 8; b--)
      if (r[b]) r = r ^ (24'h000107 << (b - 8));
    return r[7:0];
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (run_cmp) begin
      if (!rx_dc) chk("rxdata", 32'(bus.rxdata), 32'(exp_rx));
      if (!rdy_dc && !hold_mode) chk("pckt_rdy", 32'(bus.pckt_rdy), 32'(exp_rdy));
      chk("err_exclusive", 32'(bus.frm_err & bus.crc_err), 32'd0);
      chk("pulse_width", 32'((bus.frm_err & prev_frm) | (bus.crc_err & prev_crc)), 32'd0);
      obs_frm += int'(bus.frm_err);
      obs_crc += int'(bus.crc_err);
      if (bus.pckt_rdy && !prev_rdy) rdy_rise++;
      prev_rdy = bus.pckt_rdy;
      prev_frm = bus.frm_err;
      prev_crc = bus.crc_err;
    end
  end

  task automatic line(input logic bp, input logic am, input int clks);
    bus.Bp = bp;
    bus.Am = am;
    repeat (clks) @(posedge clk);
    #1;
  endtask

  task automatic idle_bits(input int n);
    line(1'b1, 1'b0, n * BD);
  endtask

  // bad_bit<0: no line error; bad_kind is the level driven on both wires
  task automatic send_byte(input logic [7:0] v, input int idx, input int bad_bit,
                           input logic bad_kind, input logic stop_v);
    if (idx == 0) rdy_dc = 1'b1;
    line(1'b0, 1'b1, BD);
    if (idx == 0) begin
      exp_rdy = 1'b0;
      rdy_dc  = 1'b0;
    end
    for (int i = 0; i < 8; i++) begin
      if (i == bad_bit) begin
        line(bad_kind, bad_kind, BD);
        exp_frm++;
        idle_bits(2);
        return;
      end
      line(v[i], ~v[i], BD);
    end
    if (!stop_v) begin
      line(1'b0, 1'b1, BD);
      exp_frm++;
      idle_bits(1);
      return;
    end
    rx_dc  = (idx == 1);
    rdy_dc = (idx == 2);
    line(1'b1, 1'b0, BD);
    case (idx)
      0: m_b0 = v;
      1: begin m_b1 = v; exp_rx = {m_b0, v}; end
      default: begin
        if (crc_ref({m_b0, m_b1}) == v) exp_rdy = !hold_mode;
        else                            exp_crc++;
      end
    endcase
    rx_dc  = 1'b0;
    rdy_dc = 1'b0;
  endtask

  task automatic send_pkt(input logic [15:0] d, input logic [7:0] c, input int g01, input int g12);
    send_byte(d[15:8], 0, -1, 1'b0, 1'b1);
    idle_bits(g01);
    send_byte(d[7:0], 1, -1, 1'b0, 1'b1);
    idle_bits(g12);
    send_byte(c, 2, -1, 1'b0, 1'b1);
    idle_bits(1);
  endtask

  task automatic clr_pulse();
    bus.clr_pckt_rdy = 1'b1;
    @(posedge clk); #1;
    bus.clr_pckt_rdy = 1'b0;
    exp_rdy = 1'b0;
  endtask

  task automatic check_counts(input string nm);
    chk({nm, "_frm_cnt"}, 32'(obs_frm), 32'(exp_frm));
    chk({nm, "_crc_cnt"}, 32'(obs_crc), 32'(exp_crc));
  endtask

  initial begin
    int          c0, r0, k, kb;
    logic [15:0] d;
    logic [7:0]  c;
    logic [7:0]  pb [3];

    bus.Bp = 1'b1; bus.Am = 1'b0; bus.clr_pckt_rdy = 1'b0;
    exp_rx = 16'h0; exp_rdy = 1'b0;
    exp_frm = 0; exp_crc = 0; obs_frm = 0; obs_crc = 0; rdy_rise = 0;
    rx_dc = 1'b0; rdy_dc = 1'b0; hold_mode = 1'b0; run_cmp = 1'b0;
    prev_rdy = 1'b0; prev_frm = 1'b0; prev_crc = 1'b0;
    m_b0 = 8'h0; m_b1 = 8'h0;

    repeat (3) @(posedge clk); #1;
    chk("reset_rxdata", 32'(bus.rxdata), 32'h0);
    chk("reset_rdy", 32'(bus.pckt_rdy), 32'd0);
    chk("reset_frm", 32'(bus.frm_err), 32'd0);
    chk("reset_crc", 32'(bus.crc_err), 32'd0);
    chk("model_crc_1234", 32'(crc_ref(16'h1234)), 32'hF1);
    chk("model_crc_abcd", 32'(crc_ref(16'hABCD)), 32'hE2);
    rst = 1'b0;
    run_cmp = 1'b1;
    idle_bits(2);

    // Basic good packet
    send_pkt(16'h1234, 8'hF1, 0, 0);
    chk("pkt1234_rx", 32'(bus.rxdata), 32'h1234);
    chk("pkt1234_rdy", 32'(bus.pckt_rdy), 32'd1);
    check_counts("pkt1234");

    // A start glitch while pckt_rdy is set must not clear it
    line(1'b0, 1'b1, 2);
    idle_bits(1);
    chk("glitch_keeps_rdy", 32'(bus.pckt_rdy), 32'd1);

    send_pkt(16'h9669, crc_ref(16'h9669), 0, 0);
    chk("pkt9669_rx", 32'(bus.rxdata), 32'h9669);
    chk("pkt9669_rdy", 32'(bus.pckt_rdy), 32'd1);

    // Forced-zero CRC
    c0 = obs_crc;
    send_pkt(16'hABCD, 8'h00, 0, 0);
    chk("badcrc_rx", 32'(bus.rxdata), 32'hABCD);
    chk("badcrc_rdy", 32'(bus.pckt_rdy), 32'd0);
    chk("badcrc_pulses", 32'(obs_crc - c0), 32'd1);
    check_counts("badcrc");

    // Stop bit low, then recovery
    c0 = obs_frm;
    send_byte(8'h12, 0, -1, 1'b0, 1'b0);
    chk("stoperr_pulses", 32'(obs_frm - c0), 32'd1);
    send_pkt(16'h1234, 8'hF1, 0, 0);
    chk("after_stoperr_rx", 32'(bus.rxdata), 32'h1234);
    chk("after_stoperr_rdy", 32'(bus.pckt_rdy), 32'd1);

    // Inter-byte gap timeout, then recovery from byte index 0
    c0 = obs_frm;
    send_byte(8'h12, 0, -1, 1'b0, 1'b1);
    idle_bits(GT + 1);
    exp_frm++;
    chk("gap_pulses", 32'(obs_frm - c0), 32'd1);
    send_pkt(16'h5A3C, crc_ref(16'h5A3C), 2, GT - 2);
    chk("after_gap_rx", 32'(bus.rxdata), 32'h5A3C);
    chk("after_gap_rdy", 32'(bus.pckt_rdy), 32'd1);

    // Both wires low during a data bit
    c0 = obs_frm;
    send_byte(8'h77, 0, -1, 1'b0, 1'b1);
    send_byte(8'h88, 1, 3, 1'b0, 1'b1);
    chk("lineerr_pulses", 32'(obs_frm - c0), 32'd1);
    chk("lineerr_rx_held", 32'(bus.rxdata), 32'h5A3C);

    // Glitch between bytes 0 and 1 leaves the byte index alone
    send_byte(8'hC3, 0, -1, 1'b0, 1'b1);
    line(1'b0, 1'b1, 2);
    idle_bits(1);
    send_byte(8'h3C, 1, -1, 1'b0, 1'b1);
    send_byte(crc_ref(16'hC33C), 2, -1, 1'b0, 1'b1);
    idle_bits(1);
    chk("glitch_mid_rx", 32'(bus.rxdata), 32'hC33C);
    chk("glitch_mid_rdy", 32'(bus.pckt_rdy), 32'd1);

    clr_pulse();
    @(negedge clk);
    chk("clr_rdy", 32'(bus.pckt_rdy), 32'd0);
    @(posedge clk); #1;

    // Clear held across the final stop sample: set still wins for one clock
    send_byte(8'h41, 0, -1, 1'b0, 1'b1);
    send_byte(8'h42, 1, -1, 1'b0, 1'b1);
    hold_mode = 1'b1;
    bus.clr_pckt_rdy = 1'b1;
    r0 = rdy_rise;
    send_byte(crc_ref(16'h4142), 2, -1, 1'b0, 1'b1);
    idle_bits(1);
    bus.clr_pckt_rdy = 1'b0;
    @(posedge clk); #1;
    exp_rdy = 1'b0;
    hold_mode = 1'b0;
    chk("hold_clr_rise", 32'(rdy_rise - r0), 32'd1);

    // Reset in the middle of byte 1
    send_pkt(16'h0F0F, crc_ref(16'h0F0F), 0, 0);
    send_byte(8'h21, 0, -1, 1'b0, 1'b1);
    line(1'b0, 1'b1, BD);
    line(1'b1, 1'b0, BD);
    line(1'b0, 1'b1, BD);
    rst = 1'b1;
    @(posedge clk); #1;
    exp_rx = 16'h0;
    exp_rdy = 1'b0;
    idle_bits(1);
    rst = 1'b0;
    idle_bits(1);
    chk("rst_mid_rx", 32'(bus.rxdata), 32'h0);
    chk("rst_mid_rdy", 32'(bus.pckt_rdy), 32'd0);
    check_counts("rst_mid");
    send_pkt(16'h1234, 8'hF1, 0, 0);
    chk("after_rst_rx", 32'(bus.rxdata), 32'h1234);

    // Randomized packets and faults
    for (int it = 0; it < 24; it++) begin
      k = int'($urandom_range(0, 9));
      d = 16'($urandom);
      c = crc_ref(d);
      if (k == 5) c = c ^ 8'($urandom_range(1, 255));
      pb[0] = d[15:8]; pb[1] = d[7:0]; pb[2] = c;
      if (k <= 5 || k == 9) begin
        if (k == 9) clr_pulse();
        send_pkt(d, c, int'($urandom_range(0, GT - 2)), int'($urandom_range(0, 2)));
      end else begin
        kb = (k == 8) ? int'($urandom_range(0, 1)) : int'($urandom_range(0, 2));
        for (int b = 0; b < kb; b++) begin
          send_byte(pb[b], b, -1, 1'b0, 1'b1);
          idle_bits(int'($urandom_range(0, 2)));
        end
        if (k == 6) begin
          send_byte(pb[kb], kb, int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 1'b1);
        end else if (k == 7) begin
          send_byte(pb[kb], kb, -1, 1'b0, 1'b0);
        end else begin
          send_byte(pb[kb], kb, -1, 1'b0, 1'b1);
          idle_bits(GT + 1);
          exp_frm++;
        end
      end
      idle_bits(int'($urandom_range(1, 3)));
      check_counts("random");
    end

    idle_bits(2);
    check_counts("final");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
